// File: rtl/counter_modn.sv
// Modulo-MOD up/down counter with clear, clipped load, registered wrap pulse
// and combinational terminal count for cascading digit stages.
module counter_modn #(
  parameter int unsigned MOD   = 10,
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_cout,
  output logic             o_tc
);

  if (MOD < 2) begin : g_mod_check
    $error("counter_modn: MOD must be at least 2");
  end
  if ((64'd1 << WIDTH) < 64'(MOD)) begin : g_width_check
    $error("counter_modn: WIDTH too narrow to hold MOD-1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_cnt_q, r_cnt_d;
  logic             r_cout_q, r_cout_d;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_cnt_q == MaxVal);
  assign w_at_zero = (r_cnt_q == '0);

  // Wrap is detected by compare, never by overflow, so non-power-of-2 MOD works.
  always_comb begin
    r_cnt_d  = r_cnt_q;
    r_cout_d = 1'b0;
    if (i_clr) begin
      r_cnt_d = '0;
    end else if (i_load) begin
      r_cnt_d = (i_load_val > MaxVal) ? MaxVal : i_load_val;
    end else if (i_en) begin
      if (i_up_dn) begin
        if (w_at_max) begin
          r_cnt_d  = '0;
          r_cout_d = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          r_cnt_d  = MaxVal;
          r_cout_d = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_q  <= '0;
      r_cout_q <= 1'b0;
    end else begin
      r_cnt_q  <= r_cnt_d;
      r_cout_q <= r_cout_d;
    end
  end

  assign o_cnt  = r_cnt_q;
  assign o_cout = r_cout_q;
  assign o_tc   = i_en & (i_up_dn ? w_at_max : w_at_zero) & ~i_clr & ~i_load;

endmodule

// File: tb/tb_counter_modn.sv
// Directed bench for counter_modn: a mod-10 instance, a two-digit cascade and a
// mod-6 instance, all sharing one clock and reset.
module tb_counter_modn;

  logic       clk;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       cout, tc;

  logic       c_en;
  logic [3:0] u_cnt, t_cnt;
  logic       u_cout, t_cout, u_tc, t_tc;

  logic       m_en, m_load;
  logic [2:0] m_load_val;
  logic [2:0] m_cnt;
  logic       m_cout, m_tc;

  int n_checks = 0;
  int n_fail   = 0;

  counter_modn #(.MOD(10), .WIDTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_clr(clr),
    .i_load(load), .i_load_val(load_val), .o_cnt(cnt), .o_cout(cout), .o_tc(tc)
  );

  counter_modn #(.MOD(10), .WIDTH(4)) u_units (
    .i_clk(clk), .i_rst(rst), .i_en(c_en), .i_up_dn(1'b1), .i_clr(1'b0),
    .i_load(1'b0), .i_load_val(4'd0), .o_cnt(u_cnt), .o_cout(u_cout), .o_tc(u_tc)
  );

  counter_modn #(.MOD(10), .WIDTH(4)) u_tens (
    .i_clk(clk), .i_rst(rst), .i_en(u_tc), .i_up_dn(1'b1), .i_clr(1'b0),
    .i_load(1'b0), .i_load_val(4'd0), .o_cnt(t_cnt), .o_cout(t_cout), .o_tc(t_tc)
  );

  counter_modn #(.MOD(6), .WIDTH(3)) u_m6 (
    .i_clk(clk), .i_rst(rst), .i_en(m_en), .i_up_dn(1'b1), .i_clr(1'b0),
    .i_load(m_load), .i_load_val(m_load_val), .o_cnt(m_cnt), .o_cout(m_cout), .o_tc(m_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    c_en = 1'b0; m_en = 1'b0; m_load = 1'b0; m_load_val = 3'd0;
    #1;
    check("reset_cnt", 32'(cnt), 0);
    check("reset_cout", 32'(cout), 0);
    tick();
    tick();
    rst = 1'b0;

    // Up count, 12 cycles
    en = 1'b1; up_dn = 1'b1;
    #1;
    for (int k = 0; k <= 12; k++) begin
      check($sformatf("up_cnt_%0d", k), 32'(cnt), k % 10);
      check($sformatf("up_cout_%0d", k), 32'(cout), (k > 0 && k % 10 == 0) ? 1 : 0);
      check($sformatf("up_tc_%0d", k), 32'(tc), (k % 10 == 9) ? 1 : 0);
      tick();
    end

    // Down count from reset
    rst = 1'b1;
    #1;
    check("rst2_cnt", 32'(cnt), 0);
    rst = 1'b0; up_dn = 1'b0; en = 1'b1;
    #1;
    for (int k = 0; k <= 11; k++) begin
      int e;
      e = (10 - (k % 10)) % 10;
      check($sformatf("dn_cnt_%0d", k), 32'(cnt), e);
      check($sformatf("dn_cout_%0d", k), 32'(cout), (k > 0 && e == 9) ? 1 : 0);
      check($sformatf("dn_tc_%0d", k), 32'(tc), (e == 0) ? 1 : 0);
      tick();
    end

    // Load and priority
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
    #1;
    check("load7_tc", 32'(tc), 0);
    tick();
    check("load7_cnt", 32'(cnt), 7);
    check("load7_cout", 32'(cout), 0);
    load_val = 4'd12;
    tick();
    check("load12_cnt", 32'(cnt), 9);
    check("load12_cout", 32'(cout), 0);
    load = 1'b0; en = 1'b1;
    #1;
    check("tc_at9", 32'(tc), 1);
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    #1;
    check("clr_load_en_tc", 32'(tc), 0);
    tick();
    check("clr_load_en_cnt", 32'(cnt), 0);
    check("clr_load_en_cout", 32'(cout), 0);
    clr = 1'b0; en = 1'b0; load_val = 4'd4;
    tick();
    check("load4_cnt", 32'(cnt), 4);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_cnt_%0d", k), 32'(cnt), 4);
      check($sformatf("hold_cout_%0d", k), 32'(cout), 0);
    end

    // Direction flip at zero
    clr = 1'b1;
    tick();
    check("clr_cnt", 32'(cnt), 0);
    clr = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check("flip_cnt", 32'(cnt), 9);
    check("flip_cout", 32'(cout), 1);
    tick();
    check("flip_next_cnt", 32'(cnt), 8);
    check("flip_next_cout", 32'(cout), 0);

    // Async reset mid-count
    clr = 1'b1;
    tick();
    clr = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("mid_cnt6", 32'(cnt), 6);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(cnt), 0);
    check("async_rst_cout", 32'(cout), 0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k <= 2; k++) begin
      check($sformatf("resume_cnt_%0d", k), 32'(cnt), k);
      tick();
    end
    en = 1'b0;

    // Two-digit cascade
    c_en = 1'b1;
    #1;
    for (int k = 0; k <= 104; k++) begin
      check($sformatf("casc_val_%0d", k), 32'(t_cnt) * 10 + 32'(u_cnt), k % 100);
      check($sformatf("casc_tcout_%0d", k), 32'(t_cout), (k == 100) ? 1 : 0);
      tick();
    end
    c_en = 1'b0;

    // Mod-6 instance, 3-bit count
    m_en = 1'b1;
    #1;
    for (int k = 0; k <= 13; k++) begin
      check($sformatf("m6_cnt_%0d", k), 32'(m_cnt), k % 6);
      check($sformatf("m6_tc_%0d", k), 32'(m_tc), (k % 6 == 5) ? 1 : 0);
      tick();
    end
    m_en = 1'b0; m_load = 1'b1; m_load_val = 3'd7;
    tick();
    check("m6_load7_cnt", 32'(m_cnt), 5);
    check("m6_load7_cout", 32'(m_cout), 0);
    m_load_val = 3'd3;
    tick();
    check("m6_load3_cnt", 32'(m_cnt), 3);
    m_load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_modn.md
# counter_modn

Parametrised modulo-N counter, the general-purpose successor to the fixed decade counter. It counts up or down with enable, synchronous clear, and synchronous load. It provides a registered wrap pulse (`cout`) and a combinational terminal-count output (`tc`) for cascading stages into multi-digit counters. It sits in timer, prescaler and display-digit paths wherever a fixed mod-10 counter was used before.

## Interface
- `MOD`, default 10: counter modulus; `cnt` range is 0..MOD-1; legal MOD ≥ 2.
- `WIDTH`, default 4: width of `cnt` and `load_val`; 2^WIDTH ≥ MOD is required, otherwise elaboration fails on a width check.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: count enable; a cascaded stage takes the previous stage's `tc` here.
- `up_dn` input 1: direction; 1 = up, 0 = down.
- `clr` input 1: synchronous clear to 0.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input WIDTH: value loaded when `load`=1.
- `cnt` output WIDTH: current count, registered.
- `cout` output 1: registered wrap pulse.
- `tc` output 1: combinational terminal count, intended for cascading.

## Operation
- Priority per clock edge: `rst` (async) > `clr` > `load` > `en` > hold.
- `clr`=1: `cnt` becomes 0, `cout` becomes 0.
- `load`=1 (with `clr`=0):
  - `cnt` becomes `load_val` if `load_val` < MOD.
  - Otherwise `cnt` becomes MOD-1 (clipped, never out of range).
  - `cout` becomes 0.
- `en`=1, `up_dn`=1: `cnt` becomes `cnt`+1, or 0 when `cnt`==MOD-1 (up-wrap).
- `en`=1, `up_dn`=0: `cnt` becomes `cnt`-1, or MOD-1 when `cnt`==0 (down-wrap).
- `en`=0: `cnt` holds; `cout` becomes 0.
- `cout` is 1 for exactly the one cycle in which the post-wrap value (0 going up, MOD-1 going down) is first presented on `cnt` after a counting wrap.
  - Loading or clearing to the wrap value does not raise `cout`.
- `tc` = `en` & (`up_dn` ? `cnt`==MOD-1 : `cnt`==0) & ~`clr` & ~`load`.
  - `tc` is high in the cycle before a wrap.
  - It feeds the `en` of the next stage, so that stage steps on the same edge.
- Direction change takes effect on the next enabled edge; there is no pipeline state.
- All arithmetic is in WIDTH bits. Wrap is decided by compare against MOD-1/0, never by natural overflow, so non-power-of-2 MOD works.

## Timing
- Reset (async assert, any time including mid-count): `cnt`=0 and `cout`=0 immediately, without waiting for a clock edge.
- `tc` after reset follows its equation (e.g. 1 if `en`=1 and `up_dn`=0).
- Reset deassertion is synchronous to use; the first count edge is the first rising `clk` with `rst`=0.
- Latency:
  - `en`/`clr`/`load` → `cnt`: 1 cycle.
  - `cnt` → `tc`: combinational, 0 cycles.
  - Wrap → `cout`: `cout` coincides with the wrapped `cnt` value (same register edge).
- `cout` is never high for two consecutive cycles unless MOD wraps occur on consecutive edges. This is impossible for MOD ≥ 2 with constant direction.
- Direction flip at the boundary: with `cnt`=0, `up_dn` changed 1→0 and `en`=1 gives `cnt`=MOD-1 and `cout`=1 next cycle (a down-wrap).
- Simultaneous `clr`+`load`+`en`: clear wins; `cnt`=0, `cout`=0, `tc`=0.

## Test plan
- MOD=10, reset then `en`=1, `up_dn`=1 for 12 cycles:
  - `cnt` runs 0,1,…,9,0,1.
  - `tc`=1 only while `cnt`=9.
  - `cout`=1 only in the cycle `cnt` returns to 0.
- Down count from reset with `up_dn`=0, `en`=1:
  - `cnt` runs 0 → 9 → 8 … 0 → 9.
  - `cout`=1 on each cycle `cnt` becomes 9.
  - `tc`=1 while `cnt`=0.
- Load and priority:
  - `load_val`=7 gives `cnt`=7 next cycle, `cout`=0.
  - `load_val`=12 gives `cnt`=9.
  - `clr`=`load`=`en`=1 with `load_val`=5 gives `cnt`=0, `tc`=0.
  - `en`=0 for 5 cycles: `cnt` holds.
- Async reset mid-count: at `cnt`=6, assert `rst` between clock edges → `cnt`=0 and `cout`=0 before the next rising edge. After release, counting resumes 0,1,2.
- Cascade two instances, MOD=10 (units `tc` → tens `en`), `en`=1 for 105 cycles:
  - Tens:units steps 00…99 → 00 → 04.
  - Tens `cout` pulses once at 99→00.
- MOD=6, WIDTH=3, up count:
  - `cnt` wraps 5 → 0 and never reaches 6 or 7.
  - Also with MOD=6, WIDTH=3: `load_val`=7 clips to 5.
